// File: rtl/game_sequencer.sv
// Match-level controller for the ball-and-paddle game: phase sequencing, scoring,
// serve direction and winner detection, with datapath enables decoded from the phase.
module game_sequencer #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       miss_p1,
  input  logic       miss_p2,
  output logic [2:0] state,
  output logic       paddle_en,
  output logic       ball_en,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_PAUSE = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam logic [3:0] LP_WIN   = 4'(WIN_SCORE);
  localparam logic [7:0] LP_SERVE = 8'(SERVE_FRAMES);
  localparam logic [7:0] LP_POINT = 8'(POINT_FRAMES);

  state_t     r_state;
  logic       r_start_prev;
  logic [7:0] r_frames;
  logic [3:0] r_score1;
  logic [3:0] r_score2;
  logic       r_serve_dir;
  logic [1:0] r_winner;

  logic       w_start_rise;
  logic       w_miss_any;
  logic [7:0] w_frames_inc;
  logic [3:0] w_score1_nxt;
  logic [3:0] w_score2_nxt;
  logic       w_win1;
  logic       w_win2;

  assign w_start_rise = start & ~r_start_prev;
  assign w_miss_any   = miss_p1 | miss_p2;
  // The current tick is included so exit lands exactly on the Nth tick.
  assign w_frames_inc = r_frames + 8'd1;
  assign w_score1_nxt = r_score1 + {3'b000, miss_p2};
  assign w_score2_nxt = r_score2 + {3'b000, miss_p1};
  assign w_win1       = (w_score1_nxt == LP_WIN);
  assign w_win2       = (w_score2_nxt == LP_WIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_start_prev <= 1'b0;
      r_frames     <= 8'd0;
      r_score1     <= 4'd0;
      r_score2     <= 4'd0;
      r_serve_dir  <= 1'b0;
      r_winner     <= 2'b00;
    end else begin
      r_start_prev <= start;
      case (r_state)
        S_IDLE: begin
          r_frames <= 8'd0;
          if (w_start_rise) begin
            r_score1    <= 4'd0;
            r_score2    <= 4'd0;
            r_serve_dir <= 1'b1;
            r_state     <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (frame_tick) begin
            if (w_frames_inc == LP_SERVE) begin
              r_frames <= 8'd0;
              r_state  <= S_PLAY;
            end else begin
              r_frames <= w_frames_inc;
            end
          end
        end
        S_PLAY: begin
          r_frames <= 8'd0;
          // A miss wins over a simultaneous start press.
          if (w_miss_any) begin
            r_score1 <= w_score1_nxt;
            r_score2 <= w_score2_nxt;
            if (miss_p1 && !miss_p2) r_serve_dir <= 1'b0;
            else if (miss_p2 && !miss_p1) r_serve_dir <= 1'b1;
            r_winner <= {w_win2, w_win1};
            r_state  <= (w_win1 || w_win2) ? S_OVER : S_POINT;
          end else if (w_start_rise) begin
            r_state <= S_PAUSE;
          end
        end
        S_POINT: begin
          if (frame_tick) begin
            if (w_frames_inc == LP_POINT) begin
              r_frames <= 8'd0;
              r_state  <= S_SERVE;
            end else begin
              r_frames <= w_frames_inc;
            end
          end
        end
        S_PAUSE: begin
          r_frames <= 8'd0;
          if (w_start_rise) r_state <= S_PLAY;
        end
        S_OVER: begin
          r_frames <= 8'd0;
          if (w_start_rise) begin
            r_score1    <= 4'd0;
            r_score2    <= 4'd0;
            r_winner    <= 2'b00;
            r_serve_dir <= 1'b1;
            r_state     <= S_SERVE;
          end
        end
        default: begin
          r_frames <= 8'd0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    paddle_en = 1'b0;
    ball_en   = 1'b0;
    ball_hold = 1'b1;
    case (r_state)
      S_SERVE: paddle_en = 1'b1;
      S_PLAY: begin
        paddle_en = 1'b1;
        ball_en   = 1'b1;
        ball_hold = 1'b0;
      end
      S_POINT: paddle_en = 1'b1;
      S_PAUSE: ball_hold = 1'b0;
      default: begin
        paddle_en = 1'b0;
        ball_en   = 1'b0;
        ball_hold = 1'b1;
      end
    endcase
  end

  assign state     = r_state;
  assign serve_dir = r_serve_dir;
  assign score1    = r_score1;
  assign score2    = r_score2;
  assign winner    = r_winner;

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Match-level controller for the ball-and-paddle game. It sequences the paddle and ball datapaths through idle, serve, rally, point-pause, pause and game-over phases. It keeps both players' scores, decides serve direction and detects the winner. It sits between the button inputs and the paddle/ball blocks, and gates their enables from the per-frame tick.

## Interface
- WIN_SCORE, 7: points needed to win; legal range 1..15.
- SERVE_FRAMES, 60: frame ticks spent in SERVE before the ball is released; legal range 1..255.
- POINT_FRAMES, 90: frame ticks spent in POINT after a miss; legal range 1..255.

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  synchronised start/pause button level; block edge-detects it internally
- miss_p1  in  1  one-cycle pulse: ball passed player 1's paddle
- miss_p2  in  1  one-cycle pulse: ball passed player 2's paddle
- state  out  3  0=IDLE, 1=SERVE, 2=PLAY, 3=POINT, 4=PAUSE, 5=OVER
- paddle_en  out  1  paddle controller may move paddles
- ball_en  out  1  ball position may advance
- ball_hold  out  1  ball held at centre (ball logic reloads its start position)
- serve_dir  out  1  0 = serve toward player 1, 1 = serve toward player 2
- score1  out  4  player 1 score
- score2  out  4  player 2 score
- winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw

## Operation
- start_rise = start & ~start_prev. start_prev is a register that resets to 0.
- Outputs are Moore-decoded from the state register, except scores, winner and serve_dir, which are registers.
- IDLE: paddle_en=0, ball_en=0, ball_hold=1. On start_rise, clear the scores, set serve_dir=1 and go to SERVE.
- SERVE: paddle_en=1, ball_en=0, ball_hold=1. The 8-bit frame counter counts frame_tick. On the SERVE_FRAMES-th tick, go to PLAY.
- PLAY: paddle_en=1, ball_en=1, ball_hold=0.
  - miss_p1 only: score2++, serve_dir=0.
  - miss_p2 only: score1++, serve_dir=1.
  - Both together: both scores increment; serve_dir is unchanged.
  - After any miss: go to OVER if either updated score equals WIN_SCORE, otherwise go to POINT.
  - start_rise with no miss in the same cycle: go to PAUSE.
- POINT: paddle_en=1, ball_en=0, ball_hold=1. On the POINT_FRAMES-th tick, go to SERVE.
- PAUSE: paddle_en=0, ball_en=0, ball_hold=0 (ball frozen in place). Misses are ignored. On start_rise, go to PLAY.
- OVER: paddle_en=0, ball_en=0, ball_hold=1.
  - winner=01 if score1 reached WIN_SCORE, 10 if score2 did, 11 if both did in the same cycle.
  - On start_rise: clear scores and winner, set serve_dir=1, go to SERVE.
- Frame counter: cleared on every state change and held at 0 outside SERVE/POINT. The counter compare uses the counter value plus the current tick, so exit happens exactly on the Nth tick.
- Misses outside PLAY are ignored.
- start_rise in SERVE or POINT is ignored.
- Scores never exceed WIN_SCORE, because play stops at WIN_SCORE. No wrap-around logic is required.
- Unused state encodings 6 and 7 return to IDLE on the next clock.

## Timing
- Reset values: state=0 (IDLE), paddle_en=0, ball_en=0, ball_hold=1, serve_dir=0, score1=0, score2=0, winner=00, frame counter=0, start_prev=0.
- Reset is asynchronous and may occur mid-match. All state returns to reset values immediately; there is no residual pause or score.
- Miss pulse at cycle n: the new score, the new state (POINT/OVER), serve_dir and winner are all visible at cycle n+1. Enables follow at n+1.
- start rising at cycle n, sampled with start_prev: the state change is visible at n+1. Holding start high gives only one event.
- SERVE/POINT exit: the Nth frame_tick, counted from the first cycle the state is visible, at cycle n → new state at n+1.
- A frame_tick arriving in the same cycle as entry into SERVE/POINT is not counted.
- Simultaneous miss and start_rise in PLAY: the miss is processed and start_rise is dropped.

## Test plan
Parameters for all scenarios: WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=3.

- Reset, then start pulse → state 1 one cycle after the rise. After 2 frame_ticks, state=2, ball_en=1, ball_hold=0, serve_dir=1.
- In PLAY, pulse miss_p1 → next cycle: score2=1, state=3, serve_dir=0, ball_hold=1. After 3 ticks, state=1; after 2 more ticks, state=2.
- Drive miss_p2 three times across rallies → after the third miss: score1=3, state=5, winner=01, paddle_en=0. Then start rise → state=1, score1=0, score2=0, winner=00.
- Scores 2:2 with miss_p1 and miss_p2 in the same cycle → scores 3:3, state=5, winner=11, serve_dir unchanged.
- Pause checks:
  - In PLAY, start rise → state=4, all enables 0.
  - miss_p1 during PAUSE → no score change.
  - Second start rise → state=2.
  - start held high for 10 cycles → only one transition.
- In PLAY, miss_p2 and start rise in the same cycle → state=3, score1 incremented. Then assert rst mid-POINT → all outputs at reset values immediately, without waiting for a clock edge.
